// File: rtl/mult_booth_seq.sv
// Sequential radix-2 Booth multiplier, signed 32x32 -> low 32 bits plus overflow flag.
// One Booth step per clock; fixed 33-cycle start-to-ready latency, restartable at any time.
module mult_booth_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH:0]   acc_q;
   logic [WIDTH-1:0] q_q;
   logic             q1_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WIDTH:0]   m_ext;
   logic [WIDTH:0]   acc_sum;
   logic             last_step;
   logic             ovf;

   assign m_ext     = {m_q[WIDTH-1], m_q};
   assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
   assign busy      = (state_q != IDLE);

   // Upper product half must be a pure sign extension of product bit 31.
   assign ovf = !((&{acc_q[WIDTH-1:0], q_q[WIDTH-1]}) || !(|{acc_q[WIDTH-1:0], q_q[WIDTH-1]}));

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      acc_sum = acc_q;
      unique case ({q_q[0], q1_q})
         2'b01:   acc_sum = acc_q + m_ext;
         2'b10:   acc_sum = acc_q - m_ext;
         default: acc_sum = acc_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (ctrl_MULT) state_d = RUN;
         RUN: begin
            if (ctrl_MULT)      state_d = RUN;
            else if (last_step) state_d = DONE;
         end
         DONE:    state_d = ctrl_MULT ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         m_q            <= '0;
         acc_q          <= '0;
         q_q            <= '0;
         q1_q           <= 1'b0;
         cnt_q          <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         state_q        <= state_d;
         data_resultRDY <= 1'b0;
         if (ctrl_MULT) begin
            // A start edge in any state reloads operands and abandons any operation in flight.
            m_q   <= data_operandA;
            q_q   <= data_operandB;
            acc_q <= '0;
            q1_q  <= 1'b0;
            cnt_q <= '0;
         end else if (state_q == RUN) begin
            // Arithmetic shift right of {acc, q, q1}, replicating the accumulator sign.
            acc_q <= {acc_sum[WIDTH], acc_sum[WIDTH:1]};
            q_q   <= {acc_sum[0], q_q[WIDTH-1:1]};
            q1_q  <= q_q[0];
            cnt_q <= cnt_q + 1'b1;
         end else if (state_q == DONE) begin
            data_result    <= q_q;
            data_exception <= ovf;
            data_resultRDY <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mult_booth_seq.sv
// Self-checking bench for mult_booth_seq: directed table, random operands vs a 64-bit
// arithmetic reference, and hand-written restart / reset / held-start sequences.
module tb_mult_booth_seq;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] data_operandA, data_operandB;
   logic        ctrl_MULT;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   mult_booth_seq #(.WIDTH(32), .CNT_W(5)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        exc;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      else n_pass++;
   endtask

   // Full signed product; overflow when the top half is not a sign extension of bit 31.
   function automatic logic [32:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      return {(p[63:32] != {32{p[31]}}), p[31:0]};
   endfunction

   // Issues a one-cycle start strobe; returns at the negedge after the start edge.
   task automatic start(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Cycles (edges after the start edge) until RDY is seen; 41 if it never comes.
   task automatic wait_rdy(output int k);
      bit seen;
      seen = 1'b0;
      k    = 0;
      while (!seen && k < 41) begin
         @(negedge clock);
         k++;
         seen = data_resultRDY;
      end
   endtask

   task automatic count_rdy(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         if (data_resultRDY) pulses++;
      end
   endtask

   task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic exc, input string nm);
      int k;
      start(a, b);
      check({nm, " busy"}, busy, 1);
      wait_rdy(k);
      check({nm, " latency"}, k, 33);
      check({nm, " result"}, data_result, res);
      check({nm, " exception"}, data_exception, exc);
      check({nm, " busy at rdy"}, busy, 0);
      @(negedge clock);
      check({nm, " rdy width"}, data_resultRDY, 0);
      check({nm, " result held"}, data_result, res);
   endtask

   initial begin
      vec_t        vecs[6];
      int          k, pulses;
      logic [31:0] ra, rb;
      logic [32:0] r;

      vecs[0] = '{32'd3,        32'd5,        32'd15,       1'b0};
      vecs[1] = '{-32'sd7,      32'd6,        32'hFFFFFFD6, 1'b0};
      vecs[2] = '{32'h80000000, 32'd1,        32'h80000000, 1'b0};
      vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
      vecs[4] = '{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
      vecs[5] = '{32'h00010000, 32'h00010000, 32'h00000000, 1'b1};

      reset_n       = 1'b0;
      ctrl_MULT     = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (2) @(negedge clock);
      check("reset result", data_result, 0);
      check("reset exception", data_exception, 0);
      check("reset rdy", data_resultRDY, 0);
      check("reset busy", busy, 0);
      reset_n = 1'b1;
      count_rdy(40, pulses);
      check("idle no rdy", pulses, 0);
      check("idle busy", busy, 0);

      foreach (vecs[i])
         run_mult(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, $sformatf("vec%0d", i));

      run_mult(32'h80000000, 32'h80000000, 32'h0, 1'b1, "min_sq");

      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 1) rb = $urandom_range(0, 255) - 128;
         if (i % 4 == 2) ra = {{17{ra[15]}}, ra[14:0]};
         r = ref_mult(ra, rb);
         run_mult(ra, rb, r[31:0], r[32], $sformatf("rand%0d", i));
      end

      // Restart during RUN: first multiply must never report.
      start(32'd9, 32'd9);
      count_rdy(8, pulses);
      check("restart early rdy", pulses, 0);
      start(32'd4, -32'sd3);
      wait_rdy(k);
      check("restart latency", k, 33);
      check("restart result", data_result, 32'hFFFFFFF4);
      check("restart exception", data_exception, 0);
      count_rdy(40, pulses);
      check("restart single rdy", pulses, 0);

      // Reset mid-operation clears outputs and suppresses the pulse.
      start(32'd100, 32'd100);
      repeat (13) @(negedge clock);
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      check("midreset result", data_result, 0);
      check("midreset exception", data_exception, 0);
      check("midreset busy", busy, 0);
      check("midreset rdy", data_resultRDY, 0);
      reset_n = 1'b1;
      count_rdy(40, pulses);
      check("midreset no rdy", pulses, 0);
      run_mult(32'd2, 32'd2, 32'd4, 1'b0, "post_reset");

      // Start held high restarts every cycle; the last start edge completes normally.
      @(negedge clock);
      data_operandA = 32'd7;
      data_operandB = 32'hFFFFFFFF;
      ctrl_MULT     = 1'b1;
      count_rdy(40, pulses);
      check("held no rdy", pulses, 0);
      check("held busy", busy, 1);
      check("held result kept", data_result, 32'd4);
      ctrl_MULT = 1'b0;
      wait_rdy(k);
      check("held release latency", k, 33);
      check("held release result", data_result, 32'hFFFFFFF9);
      check("held release exception", data_exception, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
